hdmi_timing: RTL
================

# hdmi_timing

Output-side video timing generator and alignment stage for the HDMI path, in the HDMI pixel clock domain. Drives the `hx`/`hy` scan coordinates into `hdmi_upscaler` and receives its `rgb_h` pixel back. Delays blanking and sync so they line up with that pixel, and presents registered `rgb_o`/`de_o`/`hsync_o`/`vsync_o` to the TMDS encoder stage. Also produces the `new_frame` indication used to resynchronise the PPU side.

## Interface
Parameters:
- OSCREEN_WIDTH, 720, active pixels per line
- OSCREEN_HEIGHT, 480, active lines per frame
- OFRAME_WIDTH, 858, total clocks per line (≤1024)
- OFRAME_HEIGHT, 525, total lines per frame (≤1024)
- HSYNC_START, 736, first `hx` of hsync
- HSYNC_LEN, 62, hsync width in clocks
- VSYNC_START, 489, first `hy` of vsync
- VSYNC_LEN, 6, vsync height in lines
- SYNC_POL, 0, sync active level (0 = active-low)
- RGB_LATENCY, 2, clocks from `hx`/`hy` change to matching `rgb_h` valid; range 0..7
- NEWFRAME_LINE, OFRAME_HEIGHT-3, line during which `new_frame` is high

Ports:
- clk_h  in  1  HDMI pixel clock; the only clock
- rst_h  in  1  reset, asynchronous, active-low
- hx  out  10  current output column, registered
- hy  out  10  current output line, registered
- rgb_h  in  24  pixel from upscaler for the `hx`/`hy` issued RGB_LATENCY clocks earlier
- rgb_o  out  24  aligned pixel; forced 0 outside the active area
- de_o  out  1  data enable, aligned with `rgb_o`
- hsync_o  out  1  horizontal sync, aligned with `rgb_o`
- vsync_o  out  1  vertical sync, aligned with `rgb_o`
- new_frame  out  1  high for all of line NEWFRAME_LINE; not delayed

## Operation
- **Scan counter**
  - `hx` increments every clock and wraps OFRAME_WIDTH-1 → 0.
  - On that wrap `hy` increments; it wraps OFRAME_HEIGHT-1 → 0.
  - No stall or enable; the counters free-run.
- **Timing decode**, combinational from the current `hx`/`hy`:
  - de = (hx < OSCREEN_WIDTH) && (hy < OSCREEN_HEIGHT)
  - hs = HSYNC_START ≤ hx < HSYNC_START+HSYNC_LEN
  - vs = VSYNC_START ≤ hy < VSYNC_START+VSYNC_LEN; spans whole lines, edges at hx==0.
  - Comparisons are done in 11 bits so that START+LEN cannot overflow.
- **Alignment line**
  - de/hs/vs pass through an RGB_LATENCY-deep shift register.
  - At RGB_LATENCY=0 the line is bypassed (no delay).
  - Every stage resets to the blanking state: de=0, hs=0, vs=0.
- **Output register**
  - rgb_o <= de_dly ? rgb_h : 24'h0
  - de_o <= de_dly
  - hsync_o <= hs_dly ^ ~SYNC_POL
  - vsync_o <= vs_dly ^ ~SYNC_POL
- **new_frame**
  - new_frame <= (next hy == NEWFRAME_LINE).
  - It therefore rises on the same edge that `hy` becomes NEWFRAME_LINE, and falls on the edge that `hy` leaves it.
- **Parameter legality**: an elaboration-time error is raised unless all of the following hold:
  - OSCREEN_WIDTH < OFRAME_WIDTH and OSCREEN_HEIGHT < OFRAME_HEIGHT
  - HSYNC_START+HSYNC_LEN ≤ OFRAME_WIDTH and VSYNC_START+VSYNC_LEN ≤ OFRAME_HEIGHT
  - NEWFRAME_LINE < OFRAME_HEIGHT

## Timing
- **Reset values**, all asynchronous on `rst_h` low:
  - hx=0, hy=0, rgb_o=0, de_o=0, new_frame=0
  - hsync_o = vsync_o = ~SYNC_POL (inactive)
  - every delay stage cleared
- **After reset release**
  - The first rising edge advances hx to 1.
  - Outputs are valid for the coordinate (0,0) RGB_LATENCY+1 edges after release.
- **Output latency**
  - The outputs for coordinate (hx,hy) presented in cycle t appear in cycle t+RGB_LATENCY+1.
  - `rgb_h` is sampled on the edge ending cycle t+RGB_LATENCY.
- **Line and frame wrap**
  - At hx=OFRAME_WIDTH-1, hy=OFRAME_HEIGHT-1, the next edge gives hx=0, hy=0 with no extra or skipped cycle.
  - Delayed flags carry across the wrap unchanged.
- **Reset mid-frame**
  - All outputs drop to reset values immediately.
  - Stale `rgb_h` data is never passed to `rgb_o`, because de_dly is cleared.
- **Blanking** takes priority: `rgb_o`=0 whenever de_o=0, whatever `rgb_h` holds.

## Test plan
- **Small-frame counting**
  - Stimulus: OSCREEN 72x48, OFRAME 86x53.
  - Response: hx reaches 85 and wraps to 0 with hy incrementing; hy wraps 52→0; frame period exactly 4558 clocks.
- **Alignment**
  - Stimulus: RGB_LATENCY=2; model `rgb_h` = {hx,hy} delayed 2 clocks.
  - Response: every cycle with de_o=1 shows rgb_o matching the coordinate from 3 clocks earlier; de_o rises 3 clocks after hx=0 on hy=0.
- **Sync placement at defaults**
  - Response: hsync_o is low for exactly 62 clocks per line, starting 3 clocks after hx=736.
  - Response: vsync_o is low for 6×858 clocks, starting 3 clocks after hx=0 on hy=489.
- **Blanking**
  - Stimulus: drive `rgb_h`=24'hffffff constantly.
  - Response: rgb_o=0 for every cycle with de_o=0; 720×480 cycles per frame show ffffff.
- **new_frame**
  - Response: high for exactly 858 clocks per frame, coinciding with hy=522 at defaults (hy=50 in the small frame).
- **Reset mid-frame and latency 0**
  - Stimulus: assert rst_h low asynchronously at hx=300, hy=100.
  - Response: hx=0, hy=0, de_o=0, syncs inactive before the next edge.
  - Stimulus: rebuild with RGB_LATENCY=0.
  - Response: outputs lag hx by exactly 1 clock.

Source files
------------

// File: rtl/hdmi_timing.sv
// hdmi_timing: free-running HDMI scan counter with blanking/sync decode.
// Blanking and sync are delayed to line up with the pixel returned by the
// upscaler, then everything is registered once more before the TMDS encoder.
module hdmi_timing #(
   parameter int OSCREEN_WIDTH  = 720,
   parameter int OSCREEN_HEIGHT = 480,
   parameter int OFRAME_WIDTH   = 858,
   parameter int OFRAME_HEIGHT  = 525,
   parameter int HSYNC_START    = 736,
   parameter int HSYNC_LEN      = 62,
   parameter int VSYNC_START    = 489,
   parameter int VSYNC_LEN      = 6,
   parameter int SYNC_POL       = 0,
   parameter int RGB_LATENCY    = 2,
   parameter int NEWFRAME_LINE  = OFRAME_HEIGHT - 3
) (
   input  logic        clk_h,
   input  logic        rst_h,
   output logic [9:0]  hx,
   output logic [9:0]  hy,
   input  logic [23:0] rgb_h,
   output logic [23:0] rgb_o,
   output logic        de_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        new_frame
);

   localparam logic [9:0]  HX_LAST  = 10'(OFRAME_WIDTH - 1);
   localparam logic [9:0]  HY_LAST  = 10'(OFRAME_HEIGHT - 1);
   localparam logic [9:0]  NF_LINE  = 10'(NEWFRAME_LINE);
   localparam logic [10:0] ACT_W    = 11'(OSCREEN_WIDTH);
   localparam logic [10:0] ACT_H    = 11'(OSCREEN_HEIGHT);
   localparam logic [10:0] HS_BEG   = 11'(HSYNC_START);
   localparam logic [10:0] HS_END   = 11'(HSYNC_START + HSYNC_LEN);
   localparam logic [10:0] VS_BEG   = 11'(VSYNC_START);
   localparam logic [10:0] VS_END   = 11'(VSYNC_START + VSYNC_LEN);
   localparam logic        POL      = 1'(SYNC_POL);
   localparam logic        SYNC_OFF = ~POL;

   // Reject frame geometries the counters and decode cannot represent.
   if (!(OSCREEN_WIDTH < OFRAME_WIDTH && OSCREEN_HEIGHT < OFRAME_HEIGHT &&
         HSYNC_START + HSYNC_LEN <= OFRAME_WIDTH &&
         VSYNC_START + VSYNC_LEN <= OFRAME_HEIGHT &&
         NEWFRAME_LINE < OFRAME_HEIGHT && NEWFRAME_LINE >= 0 &&
         OFRAME_WIDTH <= 1024 && OFRAME_HEIGHT <= 1024 &&
         RGB_LATENCY >= 0 && RGB_LATENCY <= 7)) begin : g_bad_params
      $error("hdmi_timing: illegal frame geometry or latency parameters");
   end

   logic [9:0]  hx_next;
   logic [9:0]  hy_next;
   logic [10:0] hx_w;
   logic [10:0] hy_w;
   logic [2:0]  flags;
   logic [2:0]  flags_dly;

   // Next scan position: hx wraps every line, hy steps on that wrap.
   always_comb begin
      hx_next = hx + 10'd1;
      hy_next = hy;
      if (hx == HX_LAST) begin
         hx_next = '0;
         hy_next = (hy == HY_LAST) ? 10'd0 : hy + 10'd1;
      end
   end

   // Scan counters and new_frame, which tracks the line being entered.
   always_ff @(posedge clk_h or negedge rst_h) begin
      if (!rst_h) begin
         hx        <= '0;
         hy        <= '0;
         new_frame <= 1'b0;
      end else begin
         hx        <= hx_next;
         hy        <= hy_next;
         new_frame <= (hy_next == NF_LINE);
      end
   end

   // Widened by one bit so START+LEN compares cannot wrap.
   assign hx_w  = {1'b0, hx};
   assign hy_w  = {1'b0, hy};
   assign flags = {(hx_w < ACT_W) && (hy_w < ACT_H),
                   (hx_w >= HS_BEG) && (hx_w < HS_END),
                   (hy_w >= VS_BEG) && (hy_w < VS_END)};

   if (RGB_LATENCY == 0) begin : g_bypass
      assign flags_dly = flags;
   end else begin : g_line
      logic [2:0] line [RGB_LATENCY];

      // Delay {de,hs,vs} by the upscaler latency; stages clear to blanking.
      always_ff @(posedge clk_h or negedge rst_h) begin
         if (!rst_h) begin
            for (int i = 0; i < RGB_LATENCY; i++) line[i] <= 3'b000;
         end else begin
            line[0] <= flags;
            for (int i = 1; i < RGB_LATENCY; i++) line[i] <= line[i-1];
         end
      end

      assign flags_dly = line[RGB_LATENCY-1];
   end

   // Output register; blanking forces the pixel to black.
   always_ff @(posedge clk_h or negedge rst_h) begin
      if (!rst_h) begin
         rgb_o   <= '0;
         de_o    <= 1'b0;
         hsync_o <= SYNC_OFF;
         vsync_o <= SYNC_OFF;
      end else begin
         rgb_o   <= flags_dly[2] ? rgb_h : 24'h0;
         de_o    <= flags_dly[2];
         hsync_o <= flags_dly[1] ^ SYNC_OFF;
         vsync_o <= flags_dly[0] ^ SYNC_OFF;
      end
   end

endmodule
